// File: rtl/barry_pkg.sv
// Shared types and constants for the Barry sprite datapath.
//   SCREEN_W / SCREEN_H : visible framebuffer size in pixels
//   xcoord_t / ycoord_t : column (10 bit) and row (9 bit) coordinate types
//   drawer_state_t      : sprite drawer FSM states
//   clamp_y()           : limits a requested top row to the last legal top row
package barry_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [9:0] xcoord_t;
    typedef logic [8:0] ycoord_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ERASE  = 2'd1,
        DRAW   = 2'd2,
        FINISH = 2'd3
    } drawer_state_t;

    function automatic ycoord_t clamp_y(input ycoord_t y, input ycoord_t y_max);
        return (y > y_max) ? y_max : y;
    endfunction
endpackage

// File: rtl/barry_sprite_drawer_if.sv
// Pixel write port between a sprite drawer and the framebuffer arbiter.
//   px_x, px_y, px_color : pixel address and colour (1 = sprite, 0 = background)
//   px_valid             : write request; address/colour held while stalled
//   px_ready             : arbiter accepts the write when px_valid & px_ready
// master = sprite drawer, slave = framebuffer arbiter.
interface barry_sprite_drawer_if
    import barry_pkg::*;
();
    xcoord_t px_x;
    ycoord_t px_y;
    logic    px_color;
    logic    px_valid;
    logic    px_ready;

    modport master (output px_x, output px_y, output px_color, output px_valid,
                    input  px_ready);
    modport slave  (input  px_x, input  px_y, input  px_color, input  px_valid,
                    output px_ready);
endinterface

// File: rtl/barry_sprite_drawer_rect_walker.sv
// rect_walker: walks a W x H rectangle with fixed left column X0 in row-major
// order (column inner, row outer). Shared with the obstacle drawer.
//   clk, rst : clock, asynchronous active-high reset
//   start    : load the walker at (X0, top); has priority over advance
//   top      : top row of the rectangle, sampled on start
//   advance  : step to the next pixel
//   x, y     : current pixel
//   last     : current pixel is the bottom-right corner
module rect_walker
    import barry_pkg::*;
#(
    parameter int X0 = 80,
    parameter int W  = 20,
    parameter int H  = 40
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    start,
    input  ycoord_t top,
    input  logic    advance,
    output xcoord_t x,
    output ycoord_t y,
    output logic    last
);
    localparam xcoord_t X_FIRST = xcoord_t'(X0);
    localparam xcoord_t X_LAST  = xcoord_t'(X0 + W - 1);
    localparam ycoord_t H_M1    = ycoord_t'(H - 1);

    xcoord_t x_reg;
    ycoord_t y_reg;
    ycoord_t bottom_reg;   // top + H - 1, kept so last is a pure compare

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg      <= '0;
            y_reg      <= '0;
            bottom_reg <= '0;
        end else if (start) begin
            x_reg      <= X_FIRST;
            y_reg      <= top;
            bottom_reg <= top + H_M1;
        end else if (advance) begin
            if (x_reg == X_LAST) begin
                x_reg <= X_FIRST;
                y_reg <= y_reg + 9'd1;
            end else begin
                x_reg <= x_reg + 10'd1;
            end
        end
    end

    assign x    = x_reg;
    assign y    = y_reg;
    assign last = (x_reg == X_LAST) && (y_reg == bottom_reg);
endmodule

// File: rtl/barry_sprite_drawer.sv
// barry_sprite_drawer: once per frame, erases Barry's previous rectangle and
// draws it at the new vertical position, issuing pixel writes over a
// valid/ready port.
//   clk, reset  : game clock, asynchronous active-high reset
//   y0          : requested top row from the motion block
//   frame_start : one-cycle pulse at start of vertical blank
//   px          : pixel write port (master side)
//   busy        : high whenever not IDLE
//   done        : one-cycle pulse when a frame update completes
module barry_sprite_drawer
    import barry_pkg::*;
#(
    parameter int X0 = 80,
    parameter int W  = 20,
    parameter int H  = 40
) (
    input  logic                         clk,
    input  logic                         reset,
    input  ycoord_t                      y0,
    input  logic                         frame_start,
    barry_sprite_drawer_if.master        px,
    output logic                         busy,
    output logic                         done
);
    localparam ycoord_t Y_MAX = ycoord_t'(SCREEN_H - H);

    drawer_state_t state_reg, state_next;
    ycoord_t       y_new_reg, y_old_reg;
    logic          drawn_reg;

    ycoord_t y_clamped;
    logic    walk_start, walk_last, handshake, pix_valid;
    ycoord_t walk_top;
    xcoord_t walk_x;
    ycoord_t walk_y;

    assign y_clamped = clamp_y(y0, Y_MAX);
    assign handshake = pix_valid & px.px_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (frame_start) begin
                    if (!drawn_reg)                   state_next = DRAW;
                    else if (y_clamped == y_old_reg)  state_next = FINISH;
                    else                              state_next = ERASE;
                end
            end
            ERASE:   if (handshake && walk_last) state_next = DRAW;
            DRAW:    if (handshake && walk_last) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs and walker control
    always_comb begin
        pix_valid  = (state_reg == ERASE) || (state_reg == DRAW);
        busy       = (state_reg != IDLE);
        done       = (state_reg == FINISH);
        walk_start = 1'b0;
        walk_top   = y_new_reg;
        if (state_reg == IDLE) begin
            // Erase starts at the old position; a first draw at the new one.
            walk_top   = drawn_reg ? y_old_reg : y_clamped;
            walk_start = frame_start && (state_next != FINISH);
        end else if (state_reg == ERASE) begin
            walk_start = handshake && walk_last;
        end
    end

    // Frame bookkeeping: requested position and what is currently on screen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_new_reg <= '0;
            y_old_reg <= '0;
            drawn_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && frame_start)
                y_new_reg <= y_clamped;
            if (state_reg == DRAW && handshake && walk_last) begin
                y_old_reg <= y_new_reg;
                drawn_reg <= 1'b1;
            end
        end
    end

    rect_walker #(.X0(X0), .W(W), .H(H)) u_walker (
        .clk     (clk),
        .rst     (reset),
        .start   (walk_start),
        .top     (walk_top),
        .advance (handshake),
        .x       (walk_x),
        .y       (walk_y),
        .last    (walk_last)
    );

    assign px.px_x     = walk_x;
    assign px.px_y     = walk_y;
    assign px.px_color = (state_reg == DRAW);
    assign px.px_valid = pix_valid;
endmodule

// File: tb/tb_barry_sprite_drawer.sv
module tb_barry_sprite_drawer;
    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       c;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] y0 = '0;
    logic       frame_start = 1'b0;
    logic       busy, done;

    barry_sprite_drawer_if px_bus();

    barry_sprite_drawer dut (
        .clk         (clk),
        .reset       (reset),
        .y0          (y0),
        .frame_start (frame_start),
        .px          (px_bus),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int  n_cmp = 0;
    int  n_bad = 0;
    wr_t got_q[$];
    wr_t exp_q[$];
    int  done_cnt = 0;
    int  busy_cnt = 0;
    int  stall_err = 0;
    bit  rand_ready = 1'b0;

    // Reference state: what the screen should currently hold
    bit         model_drawn = 1'b0;
    logic [8:0] model_y_old = '0;

    // Ready driver
    initial px_bus.px_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        if (rand_ready) px_bus.px_ready = ($urandom_range(0, 1) == 1);
    end

    // Monitor: capture accepted writes, count done/busy, check stall stability
    bit  prev_stall = 1'b0;
    wr_t prev_w;
    always @(negedge clk) begin
        wr_t cur;
        cur = '{x: px_bus.px_x, y: px_bus.px_y, c: px_bus.px_color};
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (px_bus.px_valid !== 1'b1 || cur !== prev_w))
                stall_err++;
            if (px_bus.px_valid && px_bus.px_ready) got_q.push_back(cur);
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            prev_stall = px_bus.px_valid && !px_bus.px_ready;
            prev_w = cur;
        end
    end

    task automatic add_rect(input int top, input logic c);
        for (int r = top; r < top + 40; r++)
            for (int col = 80; col < 100; col++)
                exp_q.push_back('{x: 10'(col), y: 9'(r), c: c});
    endtask

    // Expected writes for one update, and the screen afterwards
    task automatic build_expected(input logic [8:0] yv);
        int yc;
        exp_q.delete();
        yc = (yv > 9'd440) ? 440 : int'(yv);
        if (model_drawn && yc == int'(model_y_old)) return;
        if (model_drawn) add_rect(int'(model_y_old), 1'b0);
        add_rect(yc, 1'b1);
        model_y_old = 9'(yc);
        model_drawn = 1'b1;
    endtask

    task automatic pulse_frame(input logic [8:0] yv);
        @(posedge clk); #1;
        y0 = yv;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    // Wait for done within a cycle budget; returns 1 if seen
    task automatic wait_done(input int start_cnt, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done_cnt > start_cnt) begin ok = 1'b1; break; end
        end
    endtask

    task automatic check_writes(input string name);
        int bad, first;
        bad = 0; first = -1;
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL %s write count: got %0d, expected %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s write content: %0d wrong, first #%0d got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                     name, bad, first, got_q[first].x, got_q[first].y, got_q[first].c,
                     exp_q[first].x, exp_q[first].y, exp_q[first].c);
        end
        n_cmp++;
        if (stall_err != 0) begin
            n_bad++;
            $display("FAIL %s stall stability: got %0d violations, expected 0", name, stall_err);
        end
    endtask

    // One full update: stimulus, wait, compare against the reference model
    task automatic do_update(input logic [8:0] yv, input string name, input int budget);
        bit ok;
        build_expected(yv);
        got_q.delete();
        done_cnt = 0; busy_cnt = 0; stall_err = 0;
        pulse_frame(yv);
        wait_done(0, budget, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s timeout: got no done, expected done within %0d cycles", name, budget);
        end
        repeat (4) @(posedge clk);
        #1;
        check_writes(name);
        n_cmp++;
        if (done_cnt !== 1) begin
            n_bad++;
            $display("FAIL %s done pulses: got %0d, expected 1", name, done_cnt);
        end
        $display("update %s y0=%0d writes=%0d busy_cycles=%0d", name, yv, got_q.size(), busy_cnt);
    endtask

    task automatic test_reset;
        #2;
        n_cmp++;
        if ({px_bus.px_valid, busy, done, px_bus.px_color} !== 4'b0 || px_bus.px_x !== 10'd0 || px_bus.px_y !== 9'd0) begin
            n_bad++;
            $display("FAIL reset outputs: got valid=%b busy=%b done=%b c=%b x=%0d y=%0d, expected all 0",
                     px_bus.px_valid, busy, done, px_bus.px_color, px_bus.px_x, px_bus.px_y);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || px_bus.px_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL idle after reset: got busy=%b valid=%b, expected 0 0", busy, px_bus.px_valid);
        end
        $display("reset checked");
    endtask

    task automatic test_first_draw;
        do_update(9'd419, "first_draw", 3000);
        n_cmp++;
        if (got_q.size() == 0 || got_q[0] !== wr_t'{x: 10'd80, y: 9'd419, c: 1'b1}) begin
            n_bad++;
            $display("FAIL first_draw first pixel: got %0d entries, expected (80,419,c1) first", got_q.size());
        end
        n_cmp++;
        if (got_q.size() == 0 || got_q[got_q.size()-1] !== wr_t'{x: 10'd99, y: 9'd458, c: 1'b1}) begin
            n_bad++;
            $display("FAIL first_draw last pixel: got %0d entries, expected (99,458,c1) last", got_q.size());
        end
    endtask

    task automatic test_repeat;
        do_update(9'd419, "repeat", 50);
        n_cmp++;
        if (busy_cnt !== 1) begin
            n_bad++;
            $display("FAIL repeat busy cycles: got %0d, expected 1", busy_cnt);
        end
    endtask

    task automatic test_move;
        do_update(9'd416, "move", 5000);
    endtask

    task automatic test_random_ready;
        rand_ready = 1'b1;
        for (int k = 0; k < 3; k++)
            do_update(9'($urandom_range(0, 511)), "rand_ready", 12000);
        rand_ready = 1'b0;
        @(posedge clk); #1 px_bus.px_ready = 1'b1;
    endtask

    task automatic test_back_to_back;
        // Frame requests arriving right after each other, including a same-position one
        do_update(9'd10, "b2b_a", 5000);
        do_update(9'd10, "b2b_b", 50);
        do_update(9'd11, "b2b_c", 5000);
    endtask

    task automatic test_clamp_and_ignore;
        bit ok;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        model_drawn = 1'b0;
        build_expected(9'd470);
        got_q.delete();
        done_cnt = 0; busy_cnt = 0; stall_err = 0;
        pulse_frame(9'd470);
        repeat (50) @(posedge clk);
        pulse_frame(9'd5);          // arrives while busy: must be dropped
        wait_done(0, 3000, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL clamp timeout: got no done, expected done within 3000 cycles");
        end
        repeat (20) @(posedge clk);
        #1;
        check_writes("clamp");
        n_cmp++;
        if (done_cnt !== 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL clamp ignore: got done=%0d busy=%b, expected 1 0", done_cnt, busy);
        end
        $display("update clamp y0=470 writes=%0d", got_q.size());
    endtask

    task automatic test_reset_mid_draw;
        bit reached;
        // Screen holds the rectangle at 440; move to 100 then reset partway into DRAW
        got_q.delete();
        stall_err = 0;
        pulse_frame(9'd100);
        reached = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (got_q.size() >= 900) begin reached = 1'b1; break; end
        end
        n_cmp++;
        if (!reached || px_bus.px_color !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_draw reach: got %0d writes color=%b, expected >=900 in DRAW", got_q.size(), px_bus.px_color);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (px_bus.px_valid !== 1'b0 || busy !== 1'b0 || px_bus.px_x !== 10'd0) begin
            n_bad++;
            $display("FAIL async reset: got valid=%b busy=%b x=%0d, expected 0 0 0", px_bus.px_valid, busy, px_bus.px_x);
        end
        #1 reset = 1'b0;
        model_drawn = 1'b0;
        $display("reset mid-draw after %0d writes", got_q.size());
        do_update(9'd200, "after_reset", 3000);
    endtask

    initial begin
        test_reset;
        test_first_draw;
        test_repeat;
        test_move;
        test_random_ready;
        test_back_to_back;
        test_clamp_and_ignore;
        test_reset_mid_draw;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
